// File: rtl/fetch_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_pkg
// Brief    : Shared processor definitions for the fetch path. Holds the
//            redirect-source encoding, the NOP constant and the redirect
//            priority helper.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_prefetch_pkg;

    // Which source, if any, steers the fetch PC this cycle.
    typedef enum logic [1:0] {
        SRC_NONE     = 2'd0,
        SRC_IRQ      = 2'd1,
        SRC_REDIRECT = 2'd2,
        SRC_RET      = 2'd3
    } redirect_src_e;

    // Instruction word presented to decode whenever there is nothing valid.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Fixed priority: interrupt beats branch/jump, which beats return.
    function automatic redirect_src_e select_redirect(
        input logic irq,
        input logic redirect,
        input logic ret_take
    );
        redirect_src_e src;
        if (irq) begin
            src = SRC_IRQ;
        end else if (redirect) begin
            src = SRC_REDIRECT;
        end else if (ret_take) begin
            src = SRC_RET;
        end else begin
            src = SRC_NONE;
        end
        return src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Power-of-two circular instruction queue with push, pop and a
//            single-cycle flush. Push and pop together keep occupancy
//            unchanged, including when the queue is full.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DW    = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign full      = (r_count == (PW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !rst) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch
// Brief    : Instruction prefetch unit. Issues sequential fetches against a
//            one-cycle instruction memory, buffers responses in a small
//            queue, and handles interrupt / branch / return redirects with
//            queue flush. Holds the fetch PC, the word-assembled return
//            register and in-flight tracking.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int            W          = 16,
    parameter int            AW         = 32,
    parameter int            DEPTH      = 4,
    parameter logic [AW-1:0] START_ADDR = '0,
    parameter logic [AW-1:0] ISR_ADDR   = '0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    output logic                                      imem_req,
    output logic [AW-1:0]                             imem_addr,
    input  logic [W-1:0]                              imem_rdata,
    input  logic                                      redirect,
    input  logic [AW-1:0]                             redirect_addr,
    input  logic                                      irq,
    input  logic                                      pop_en,
    input  logic [(((AW/W) > 1) ? $clog2(AW/W) : 1)-1:0] pop_sel,
    input  logic [W-1:0]                              pop_word,
    input  logic                                      ret_take,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [W-1:0]                              out_instr,
    output logic [AW-1:0]                             out_pc,
    output logic [AW-1:0]                             out_pc_1,
    output logic [AW-1:0]                             irq_ret_pc
);

    localparam int SLICES = AW / W;
    localparam int SELW   = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int DW     = AW + W;

    // Architectural state
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_ret;
    logic          r_infl_v;
    logic [AW-1:0] r_infl_pc;

    // Redirect decode
    redirect_src_e w_src;
    logic          w_redir;

    // Queue interface
    logic          w_q_push;
    logic          w_q_pop;
    logic [DW-1:0] w_q_head;
    logic          w_q_full;
    logic          w_q_empty;
    logic [CW-1:0] w_q_count;

    // Head selection and handshake
    logic [DW-1:0] w_head;
    logic          w_head_v;
    logic          w_rsp_v;
    logic          w_xfer;
    logic [CW-1:0] w_occ;
    logic          w_credit;

    assign w_src   = select_redirect(irq, redirect, ret_take);
    assign w_redir = (w_src != SRC_NONE);

    // The memory answers exactly one cycle after a request, so an in-flight
    // request is by definition the response arriving this cycle.
    assign w_rsp_v = r_infl_v;

    // Credit counts queued entries plus the one possibly in flight.
    assign w_occ    = w_q_count + CW'(r_infl_v);
    assign w_credit = (w_occ < CW'(DEPTH));

    assign imem_req  = !rst && !w_redir && w_credit;
    assign imem_addr = r_pc;

    // An empty queue lets the arriving response go straight to decode, so
    // out_valid follows the request by one cycle.
    assign w_head   = w_q_empty ? {r_infl_pc, imem_rdata} : w_q_head;
    assign w_head_v = !w_q_empty || w_rsp_v;

    assign out_valid = w_head_v && !w_redir && !rst;
    assign out_pc    = w_head[DW-1:W];
    assign out_pc_1  = w_head[DW-1:W] + AW'(1);
    assign out_instr = out_valid ? w_head[W-1:0] : W'(NOP_INSTR);
    assign w_xfer    = out_valid && out_ready;

    // A bypassed response that is consumed immediately never enters the queue.
    assign w_q_pop  = w_xfer && !w_q_empty;
    assign w_q_push = w_rsp_v && !w_redir && !rst
                      && !(w_q_empty && w_xfer)
                      && (!w_q_full || w_q_pop);

    // The resume point is taken before any flush so it names the oldest
    // instruction that has not yet reached decode.
    assign irq_ret_pc = w_head_v ? w_head[DW-1:W] :
                        r_infl_v ? r_infl_pc      :
                                   r_pc;

    fetch_queue #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (w_redir),
        .push      (w_q_push),
        .push_data ({r_infl_pc, imem_rdata}),
        .pop       (w_q_pop),
        .head_data (w_q_head),
        .full      (w_q_full),
        .empty     (w_q_empty),
        .count     (w_q_count)
    );

    // Fetch PC: redirect target wins, otherwise advance on each issued request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= START_ADDR;
        end else begin
            case (w_src)
                SRC_IRQ:      r_pc <= ISR_ADDR;
                SRC_REDIRECT: r_pc <= redirect_addr;
                SRC_RET:      r_pc <= r_ret;
                default: begin
                    if (imem_req) begin
                        r_pc <= r_pc + AW'(1);
                    end
                end
            endcase
        end
    end

    // In-flight tracker; a redirect or reset suppresses the request, so
    // nothing issued before them can be pushed afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_infl_v  <= 1'b0;
            r_infl_pc <= '0;
        end else begin
            r_infl_v <= imem_req;
            if (imem_req) begin
                r_infl_pc <= r_pc;
            end
        end
    end

    // Return register assembled one W-bit slice at a time; ret_take in the
    // same cycle naturally sees the value before this write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ret <= '0;
        end else if (pop_en) begin
            for (int k = 0; k < SLICES; k++) begin
                if (pop_sel == SELW'(k)) begin
                    r_ret[k*W +: W] <= pop_word;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch
// Brief    : Self-checking bench for fetch_prefetch. Expected PCs are queued
//            whenever the fetch stream is (re)started and compared against
//            every decode transfer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_prefetch;

    localparam int W     = 16;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    typedef logic [AW-1:0] pc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus
    logic          rst;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          irq;
    logic          pop_en;
    logic [0:0]    pop_sel;
    logic [W-1:0]  pop_word;
    logic          ret_take;
    logic          out_ready;

    // Main DUT observations
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [W-1:0]  imem_rdata;
    logic          out_valid;
    logic [W-1:0]  out_instr;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_pc_1;
    logic [AW-1:0] irq_ret_pc;

    // Wrap-around DUT observations
    logic          imem_req_b;
    logic [AW-1:0] imem_addr_b;
    logic [W-1:0]  imem_rdata_b;
    logic          out_valid_b;
    logic [W-1:0]  out_instr_b;
    logic [AW-1:0] out_pc_b;
    logic [AW-1:0] out_pc_1_b;
    logic [AW-1:0] irq_ret_pc_b;

    pc_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_xfer   = 0;

    fetch_prefetch #(
        .W(W), .AW(AW), .DEPTH(DEPTH),
        .START_ADDR(32'h0000_0000), .ISR_ADDR(32'h0000_0200)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_addr(redirect_addr), .irq(irq),
        .pop_en(pop_en), .pop_sel(pop_sel), .pop_word(pop_word), .ret_take(ret_take),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_1(out_pc_1), .irq_ret_pc(irq_ret_pc)
    );

    fetch_prefetch #(
        .W(W), .AW(AW), .DEPTH(DEPTH),
        .START_ADDR(32'hFFFF_FFFF), .ISR_ADDR(32'h0000_0000)
    ) dut_b (
        .clk(clk), .rst(rst),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .redirect(1'b0), .redirect_addr(32'h0), .irq(1'b0),
        .pop_en(1'b0), .pop_sel(1'b0), .pop_word(16'h0), .ret_take(1'b0),
        .out_valid(out_valid_b), .out_ready(1'b1), .out_instr(out_instr_b),
        .out_pc(out_pc_b), .out_pc_1(out_pc_1_b), .irq_ret_pc(irq_ret_pc_b)
    );

    // Instruction memory: word at address n is n (low W bits), one-cycle latency.
    always @(posedge clk) begin
        imem_rdata   <= imem_req   ? imem_addr[W-1:0]   : 16'hDEAD;
        imem_rdata_b <= imem_req_b ? imem_addr_b[W-1:0] : 16'hDEAD;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input pc_t start, input int n);
        sb.delete();
        for (int i = 0; i < n; i++) begin
            sb.push_back(start + pc_t'(i));
        end
    endtask

    // Scoreboard: every decode transfer must match the next expected PC.
    always @(negedge clk) begin : mon
        pc_t e;
        if (out_valid && out_ready) begin
            n_xfer++;
            if (sb.size() == 0) begin
                check("xfer_unexpected", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("xfer_pc",    64'(out_pc),    64'(e));
                check("xfer_instr", 64'(out_instr), 64'(e[W-1:0]));
                check("xfer_pc_1",  64'(out_pc_1),  64'(e + pc_t'(1)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  xfer0;
        int  nreq;
        pc_t held_pc;
        pc_t exp_head;

        rst = 1'b1; redirect = 1'b0; redirect_addr = '0; irq = 1'b0;
        pop_en = 1'b0; pop_sel = 1'b0; pop_word = '0; ret_take = 1'b0;
        out_ready = 1'b1;

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_imem_req",   64'(imem_req),     64'd0);
        check("rst_out_valid",  64'(out_valid),    64'd0);
        check("rst_fetch_pc",   64'(irq_ret_pc),   64'd0);
        check("rst_b_fetch_pc", 64'(irq_ret_pc_b), 64'hFFFF_FFFF);

        // Release: first request at START_ADDR, one instruction per cycle after
        tick();
        rst = 1'b0;
        expect_seq(32'h0, 64);
        xfer0 = n_xfer;
        @(negedge clk);
        check("first_req",       64'(imem_req),    64'd1);
        check("first_addr",      64'(imem_addr),   64'd0);
        check("first_out_valid", 64'(out_valid),   64'd0);
        check("b_first_addr",    64'(imem_addr_b), 64'hFFFF_FFFF);
        for (int i = 2; i <= 12; i++) begin
            tick();
            @(negedge clk);
            if (i == 2) begin
                check("second_out_valid", 64'(out_valid),  64'd1);
                check("b_pc_c2",          64'(out_pc_b),   64'hFFFF_FFFF);
                check("b_pc_1_c2",        64'(out_pc_1_b), 64'd0);
            end
            if (i == 3) check("b_pc_c3", 64'(out_pc_b), 64'd0);
            if (i == 4) check("b_pc_c4", 64'(out_pc_b), 64'd1);
        end
        tick();
        check("steady_xfers", 64'(n_xfer - xfer0), 64'd11);

        // Mid-operation reset, then a 10-cycle decode stall
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_imem_req",  64'(imem_req),  64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        expect_seq(32'h0, 64);
        nreq = 0;
        held_pc = '1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (imem_req) nreq++;
            if (i == 2) held_pc = out_pc;
            if (i < 10) tick();
        end
        check("stall_req_count", 64'(nreq),      64'd4);
        check("stall_req_off",   64'(imem_req),  64'd0);
        check("stall_valid",     64'(out_valid), 64'd1);
        check("stall_pc_held",   64'(out_pc),    64'(held_pc));
        check("stall_pc",        64'(out_pc),    64'd0);
        check("stall_instr",     64'(out_instr), 64'd0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
        end

        // Branch redirect with a response in flight
        redirect = 1'b1;
        redirect_addr = 32'h0000_0100;
        expect_seq(32'h100, 64);
        @(negedge clk);
        check("redir_out_valid", 64'(out_valid), 64'd0);
        check("redir_imem_req",  64'(imem_req),  64'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("redir_req",       64'(imem_req),  64'd1);
        check("redir_addr",      64'(imem_addr), 64'h100);
        check("redir_gap_valid", 64'(out_valid), 64'd0);
        tick();
        @(negedge clk);
        check("redir_valid2", 64'(out_valid), 64'd1);
        check("redir_pc2",    64'(out_pc),    64'h100);
        for (int i = 0; i < 4; i++) tick();

        // Return register assembly and return jump
        pop_en = 1'b1; pop_sel = 1'b1; pop_word = 16'h0001;
        tick();
        pop_sel = 1'b0; pop_word = 16'h2000;
        tick();
        pop_en = 1'b0; ret_take = 1'b1;
        expect_seq(32'h0001_2000, 64);
        @(negedge clk);
        check("ret_out_valid", 64'(out_valid), 64'd0);
        tick();
        ret_take = 1'b0;
        @(negedge clk);
        check("ret_addr", 64'(imem_addr), 64'h0001_2000);
        tick();
        @(negedge clk);
        check("ret_pc", 64'(out_pc), 64'h0001_2000);
        tick();
        // Write and take together: the jump uses the old register value
        pop_en = 1'b1; pop_sel = 1'b0; pop_word = 16'h3000; ret_take = 1'b1;
        expect_seq(32'h0001_2000, 64);
        tick();
        pop_en = 1'b0; ret_take = 1'b0;
        @(negedge clk);
        check("ret_old_value", 64'(imem_addr), 64'h0001_2000);
        tick(); tick();
        ret_take = 1'b1;
        expect_seq(32'h0001_3000, 64);
        tick();
        ret_take = 1'b0;
        @(negedge clk);
        check("ret_new_value", 64'(imem_addr), 64'h0001_3000);
        for (int i = 0; i < 4; i++) tick();

        // Interrupt and redirect in the same cycle
        exp_head = sb[0];
        irq = 1'b1; redirect = 1'b1; redirect_addr = 32'h0000_0300;
        expect_seq(32'h200, 64);
        @(negedge clk);
        check("irq_ret_pc",    64'(irq_ret_pc), 64'(exp_head));
        check("irq_out_valid", 64'(out_valid),  64'd0);
        tick();
        irq = 1'b0; redirect = 1'b0;
        @(negedge clk);
        check("irq_addr",          64'(imem_addr),  64'h200);
        check("irq_req",           64'(imem_req),   64'd1);
        check("irq_ret_pc_fetch",  64'(irq_ret_pc), 64'h200);
        tick();
        @(negedge clk);
        check("irq_pc", 64'(out_pc), 64'h200);
        for (int i = 0; i < 4; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
